md_sequencer: RTL and testbench

//   Multiply/divide unit sequencer for the 5-stage pipeline, sitting in E beside the ALU.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_sequencer.sv | 114 +++++++++++
 tb/tb_md_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the multiply/divide sequencer.
// MD_MADD_EN adds MADD/MADDU to the set of ops that occupy the unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that run the countdown and commit to HI/LO at its end.
  function automatic logic md_is_muldiv(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op <= MD_DIVU) || (op == MD_MADD) || (op == MD_MADDU);
`else
    return (op <= MD_DIVU);
`endif
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: latency countdown, HI/LO ownership and D-stage stall request.
// Define MD_MADD_EN to enable the MADD/MADDU accumulate ops (otherwise they are no-ops).
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  input  logic        mf_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;
  logic             start_mul_div;

  // Full {hi,lo} result; divide by zero returns the accumulator so HI/LO keep their values.
  function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;
    logic signed [31:0] sq, sr;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'h0, a};
    ub = {32'h0, b};
    sq = '0;
    sr = '0;
    md_calc = acc;
    case (op)
      MD_MULT:  md_calc = sa * sb;
      MD_MULTU: md_calc = ua * ub;
      MD_DIV: begin
        if (b == 32'h0) begin
          md_calc = acc;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          md_calc = {32'h0, 32'h8000_0000};
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          md_calc = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b != 32'h0) md_calc = {a % b, a / b};
      end
`ifdef MD_MADD_EN
      MD_MADD:  md_calc = acc + sa * sb;
      MD_MADDU: md_calc = acc + ua * ub;
`endif
      default: md_calc = acc;
    endcase
  endfunction

  assign start_mul_div = start & md_is_muldiv(md_op);
  assign busy          = (state == BUSY);
  assign stall_req     = md_use_d & (busy | start_mul_div);
  assign rd_data       = mf_sel ? hi : lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_mul_div) state_nxt = BUSY;
      BUSY: if (cnt == '0)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The result is computed once at the start edge and held in pend_* until the countdown ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == IDLE) begin
      if (start_mul_div) begin
        {pend_hi, pend_lo} <= md_calc(md_op, rs_val, rt_val, {hi, lo});
        cnt <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      end else if (start && md_op == MD_MTHI) begin
        hi <= rs_val;
      end else if (start && md_op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else if (cnt == '0) begin
      hi <= pend_hi;
      lo <= pend_lo;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus randomized ops against a
// behavioural HI/LO model (MD_MADD_EN selects the accumulate-op expectations).
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_d, mf_sel;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rd_data;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d), .mf_sel(mf_sel),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Architectural result of one op, from the instruction-set definition.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {h, l};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
`ifdef MD_MADD_EN
      3'd6: return {h, l} + sa * sb;
      3'd7: return {h, l} + ua * ub;
`endif
      default: return {h, l};
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MULT_N;
      3'd2, 3'd3: return DIV_N;
`ifdef MD_MADD_EN
      3'd6, 3'd7: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op, follow it to completion and compare against the model.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input string tag);
    logic [63:0] expv;
    int lat, cyc;
    logic exp_stall;
    expv = ref_result(op, a, b, m_hi, m_lo);
    lat  = ref_latency(op);
    exp_stall = use_d & (lat > 0);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    md_use_d = use_d; mf_sel = 1'($urandom_range(0, 1));
    #1;
    compared++;
    if (stall_req !== exp_stall) begin
      mismatched++;
      $display("[TB] FAIL %s start_stall: got %b want %b", tag, stall_req, exp_stall);
    end
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      compared++;
      if (hi !== m_hi || lo !== m_lo || stall_req !== use_d) begin
        mismatched++;
        $display("[TB] FAIL %s hold cyc%0d: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=%b",
                 tag, cyc, hi, lo, stall_req, m_hi, m_lo, use_d);
      end
      cyc++;
      @(negedge clk);
    end
    compared++;
    if (cyc != lat) begin
      mismatched++;
      $display("[TB] FAIL %s latency: got %0d want %0d", tag, cyc, lat);
    end
    m_hi = expv[63:32];
    m_lo = expv[31:0];
    compared++;
    if (hi !== m_hi || lo !== m_lo) begin
      mismatched++;
      $display("[TB] FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", tag, hi, lo, m_hi, m_lo);
    end
    compared++;
    if (rd_data !== (mf_sel ? m_hi : m_lo) || stall_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s rd_data/stall: rd=%h stall=%b want rd=%h stall=0",
               tag, rd_data, stall_req, mf_sel ? m_hi : m_lo);
    end
    md_use_d = 1'b0;
  endtask

  task automatic check_hilo(input logic [31:0] eh, input logic [31:0] el, input string tag);
    compared++;
    if (hi !== eh || lo !== el) begin
      mismatched++;
      $display("[TB] FAIL %s: hi=%h lo=%h want hi=%h lo=%h", tag, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0;
    md_use_d = 1'b1; mf_sel = 1'b0;
    #12;
    compared++;
    if (busy !== 1'b0 || stall_req !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset: busy=%b stall=%b hi=%h lo=%h want 0/0/0/0",
               busy, stall_req, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1; md_use_d = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_const");
  endtask

  task automatic test_div();
    run_md(3'd3, 32'd17, 32'd5, 1'b0, "divu_17_5");
    check_hilo(32'd2, 32'd3, "divu_const");
    run_md(3'd2, 32'hFFFF_FFEF, 32'd5, 1'b0, "div_m17_5");
    check_hilo(32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_const");
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    check_hilo(32'h0, 32'h8000_0000, "div_ovf_const");
  endtask

  task automatic test_stall();
    run_md(3'd0, 32'd7, 32'd6, 1'b1, "stall_mult");
    compared++;
    if (rd_data !== (mf_sel ? 32'd0 : 32'd42)) begin
      mismatched++;
      $display("[TB] FAIL stall_rd: got %h want %h", rd_data, mf_sel ? 32'd0 : 32'd42);
    end
  endtask

  task automatic test_mt_divzero();
    run_md(3'd5, 32'h1234, 32'd0, 1'b0, "mtlo");
    compared++;
    if (lo !== 32'h1234) begin
      mismatched++;
      $display("[TB] FAIL mtlo_const: got %h want 00001234", lo);
    end
    run_md(3'd4, 32'h55, 32'd0, 1'b0, "mthi55");
    run_md(3'd5, 32'h55, 32'd0, 1'b0, "mtlo55");
    run_md(3'd2, 32'd99, 32'd0, 1'b1, "div_by_zero");
    check_hilo(32'h55, 32'h55, "divzero_const");
  endtask

  task automatic test_reset_abort();
    run_md(3'd4, 32'h77, 32'd0, 1'b0, "mthi77");
    run_md(3'd5, 32'h77, 32'd0, 1'b0, "mtlo77");
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; rs_val = 32'd17; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_now: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (DIV_N + 2) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_after: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    run_md(3'd4, 32'h0, 32'd0, 1'b0, "mthi0");
    run_md(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtloF");
    run_md(3'd7, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MD_MADD_EN
    check_hilo(32'd1, 32'd0, "maddu_const");
`else
    check_hilo(32'd0, 32'hFFFF_FFFF, "maddu_noop_const");
`endif
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_md(op, a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_divzero();
    test_madd();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
